// File: rtl/wallace_pipe_mult_if.sv
// Operand/product handshake bundle for wallace_pipe_mult.
// The master drives operands and accepts products; the slave is the multiplier.
interface wallace_pipe_mult_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       x;
    logic [WIDTH-1:0]       y;
    logic                   tc;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     p;
    logic                   out_tc;

    modport master (
        output in_valid, x, y, tc, out_ready,
        input  in_ready, out_valid, p, out_tc
    );

    modport slave (
        input  in_valid, x, y, tc, out_ready,
        output in_ready, out_valid, p, out_tc
    );
endinterface

// File: rtl/wallace_pipe_mult.sv
// Pipelined signed/unsigned multiplier: Baugh-Wooley partial products, Wallace 3:2 reduction,
// final carry-propagate add in the last stage. Whole pipeline freezes while the output stalls.
module wallace_pipe_mult #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 3
) (
    input logic                clk,
    input logic                rst,
    wallace_pipe_mult_if.slave bus
);
    localparam int W    = WIDTH;
    localparam int S    = STAGES;
    localparam int PW   = 2 * W;
    localparam int NR   = W + 1;
    localparam int NG   = NR / 3;
    localparam int LAST = S - 1;

    typedef logic [PW-1:0] row_t;

    function automatic int tree_levels(input int rows);
        int n;
        int l;
        n = rows;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int NLEV = tree_levels(NR);

    row_t tree_sum;
    row_t tree_car;

    always_comb begin : tree
        row_t rows [NR];
        row_t nxt  [NR];
        int   n;
        int   m;
        logic pp;
        for (int i = 0; i < NR; i++) begin
            rows[i] = '0;
        end
        // Terms pairing exactly one operand MSB with a non-MSB bit are inverted in signed mode.
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                pp = bus.x[j] & bus.y[i];
                if (bus.tc && ((i == W - 1) != (j == W - 1))) begin
                    pp = ~pp;
                end
                rows[i][i+j] = pp;
            end
        end
        rows[W][W]    = bus.tc;
        rows[W][PW-1] = bus.tc;

        n = NR;
        for (int lvl = 0; lvl < NLEV; lvl++) begin
            for (int k = 0; k < NR; k++) begin
                nxt[k] = '0;
            end
            m = 0;
            for (int g = 0; g < NG; g++) begin
                if (3 * g + 2 < n) begin
                    nxt[m]   = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
                    nxt[m+1] = ((rows[3*g] & rows[3*g+1]) | (rows[3*g] & rows[3*g+2]) |
                                (rows[3*g+1] & rows[3*g+2])) << 1;
                    m += 2;
                end
            end
            for (int k = 0; k < NR; k++) begin
                if (k >= 3 * (n / 3) && k < n) begin
                    nxt[m] = rows[k];
                    m++;
                end
            end
            n    = m;
            rows = nxt;
        end
        tree_sum = rows[0];
        tree_car = rows[1];
    end

    logic vld_q [S];
    logic vld_d [S];
    row_t sum_q [S];
    row_t sum_d [S];
    row_t car_q [S];
    row_t car_d [S];
    logic tc_q  [S];
    logic tc_d  [S];

    logic src_v [S];
    row_t src_s [S];
    row_t src_c [S];
    logic src_t [S];

    logic stall;
    logic load;

    assign stall = vld_q[LAST] & ~bus.out_ready;
    assign load  = bus.in_valid & ~stall;

    // Intermediate stages carry the redundant sum/carry pair; the last stage holds the product.
    always_comb begin
        src_v[0] = load;
        src_s[0] = tree_sum;
        src_c[0] = tree_car;
        src_t[0] = bus.tc;
        for (int k = 1; k < S; k++) begin
            src_v[k] = vld_q[k-1];
            src_s[k] = sum_q[k-1];
            src_c[k] = car_q[k-1];
            src_t[k] = tc_q[k-1];
        end
        for (int k = 0; k < S; k++) begin
            vld_d[k] = vld_q[k];
            sum_d[k] = sum_q[k];
            car_d[k] = car_q[k];
            tc_d[k]  = tc_q[k];
            if (!stall) begin
                vld_d[k] = src_v[k];
                tc_d[k]  = src_t[k];
                if (k == LAST) begin
                    sum_d[k] = src_s[k] + src_c[k];
                    car_d[k] = '0;
                end else begin
                    sum_d[k] = src_s[k];
                    car_d[k] = src_c[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < S; k++) begin
                vld_q[k] <= 1'b0;
                sum_q[k] <= '0;
                car_q[k] <= '0;
                tc_q[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < S; k++) begin
                vld_q[k] <= vld_d[k];
                sum_q[k] <= sum_d[k];
                car_q[k] <= car_d[k];
                tc_q[k]  <= tc_d[k];
            end
        end
    end

    assign bus.in_ready  = ~stall;
    assign bus.out_valid = vld_q[LAST];
    assign bus.p         = sum_q[LAST];
    assign bus.out_tc    = tc_q[LAST];

endmodule
